// File: rtl/black_box_inverter_pkg.sv
// Shared constants and per-bit helpers for the black_box_inverter leaf primitive.
// The helpers work on one bit, so callers of any width loop over them without truncation.
package black_box_inverter_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  // bypass wins over the mask; X/Z on din flows straight through the XOR
  function automatic logic inv_bit(input logic din, input logic mask, input logic byp);
    return byp ? din : (din ^ mask);
  endfunction

  // Output value seen for in=0 with bypass off: the value state resets to
  function automatic logic reset_bit(input logic mask);
    return inv_bit(1'b0, mask, 1'b0);
  endfunction

endpackage

// File: rtl/black_box_inverter_if.sv
// Data-side bundle of the inverter: input word, bypass select, output word and change count.
// The master drives in/bypass; the slave (the inverter) drives out/toggle_cnt.
interface black_box_inverter_if #(
  parameter int WIDTH = black_box_inverter_pkg::DEFAULT_WIDTH,
  parameter int CNT_W = black_box_inverter_pkg::DEFAULT_CNT_W
);

  logic [WIDTH-1:0] in;
  logic             bypass;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (output in, bypass, input out, toggle_cnt);
  modport slave  (input in, bypass, output out, toggle_cnt);

endinterface

// File: rtl/black_box_inverter_toggle_cnt.sv
// Saturating count of cycles where the watched word differs from its previous-cycle value.
// One-cycle update latency; never stalls, holds at all-ones instead of wrapping.
module black_box_inverter_toggle_cnt
  import black_box_inverter_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_MASK = {WIDTH{1'b1}},
  parameter int               CNT_W    = DEFAULT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_out,
  output logic [CNT_W-1:0] o_toggle_cnt
);

  logic [WIDTH-1:0] r_out_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_changed;
  logic             w_sat;

  // Any number of differing bits in one cycle is a single event
  assign w_changed = (i_out != r_out_q);
  assign w_sat     = (r_cnt == {CNT_W{1'b1}});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_out_q[i] <= reset_bit(RST_MASK[i]);
      end
      r_cnt <= '0;
    end else begin
      r_out_q <= i_out;
      if (w_changed && !w_sat) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_toggle_cnt = r_cnt;

endmodule

// File: rtl/black_box_inverter.sv
// Masked bitwise inverter with a bypass and an output-change counter; zero latency, or one
// cycle when BLACK_BOX_INVERTER_REG_OUT_EN is defined. No backpressure: output follows input.
module black_box_inverter
  import black_box_inverter_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}},
  parameter int               CNT_W    = DEFAULT_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  black_box_inverter_if.slave  bus
);

  logic [WIDTH-1:0] w_out_next;
  logic [WIDTH-1:0] w_out;

  always_comb begin
    w_out_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_out_next[i] = inv_bit(bus.in[i], INV_MASK[i], bus.bypass);
    end
  end

`ifdef BLACK_BOX_INVERTER_REG_OUT_EN
  logic [WIDTH-1:0] r_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_out[i] <= reset_bit(INV_MASK[i]);
      end
    end else begin
      r_out <= w_out_next;
    end
  end

  assign w_out = r_out;
`else
  // Pure combinational path: clock and reset only reach the counter
  assign w_out = w_out_next;
`endif

  assign bus.out = w_out;

  black_box_inverter_toggle_cnt #(
    .WIDTH    (WIDTH),
    .RST_MASK (INV_MASK),
    .CNT_W    (CNT_W)
  ) u_toggle_cnt (
    .i_clk        (clock),
    .i_rst        (reset),
    .i_out        (w_out),
    .o_toggle_cnt (bus.toggle_cnt)
  );

endmodule

// File: tb/tb_black_box_inverter.sv
// Directed bench for black_box_inverter: default, 8-bit masked and 3-bit-counter instances.
// Expectations adapt to BLACK_BOX_INVERTER_REG_OUT_EN where output latency differs.
module tb_black_box_inverter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  black_box_inverter_if #(.WIDTH(1), .CNT_W(16)) b0 ();
  black_box_inverter_if #(.WIDTH(8), .CNT_W(16)) b1 ();
  black_box_inverter_if #(.WIDTH(1), .CNT_W(3))  b2 ();

  black_box_inverter u_dut0 (.clock(clk), .reset(rst), .bus(b0.slave));

  black_box_inverter #(.WIDTH(8), .INV_MASK(8'h0F), .CNT_W(16)) u_dut1 (
    .clock(clk), .reset(rst), .bus(b1.slave)
  );

  black_box_inverter #(.WIDTH(1), .INV_MASK(1'b1), .CNT_W(3)) u_dut2 (
    .clock(clk), .reset(rst), .bus(b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let inputs take effect on out: immediately when combinational, after one edge when registered
  task automatic settle();
`ifdef BLACK_BOX_INVERTER_REG_OUT_EN
    step();
`else
    #1;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic       exp_now;
    logic [7:0] v;
    n_chk  = 0;
    n_pass = 0;

    rst       = 1'b1;
    b0.in     = 1'b0;
    b0.bypass = 1'b0;
    b1.in     = 8'h00;
    b1.bypass = 1'b0;
    b2.in     = 1'b0;
    b2.bypass = 1'b0;

    // Reset phase: out stays 1 for in=0 (also the registered reset value), counter clears
    step();
    step();
    chk("rst_out_in0", 32'(b0.out), 32'h1);
    chk("rst_cnt0", 32'(b0.toggle_cnt), 32'h0);
    chk("rst_cnt2", 32'(b2.toggle_cnt), 32'h0);

    // Release reset with in=1: out goes 0 (same cycle, or one edge later if registered)
    rst   = 1'b0;
    b0.in = 1'b1;
    #1;
`ifdef BLACK_BOX_INVERTER_REG_OUT_EN
    exp_now = 1'b1;
`else
    exp_now = 1'b0;
`endif
    chk("lat_in1_now", 32'(b0.out), 32'(exp_now));
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("hold_in1_c%0d", i), 32'(b0.out), 32'h0);
    end
    // Single change against the reset value of out_q
    chk("cnt_after_release", 32'(b0.toggle_cnt), 32'd1);

    // One-cycle reset, then five toggles starting from in=1
    rst = 1'b1;
    step();
    chk("cnt_rst_again", 32'(b0.toggle_cnt), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b0.in = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    step();
    chk("cnt_5_toggles", 32'(b0.toggle_cnt), 32'd5);
    step();
    step();
    chk("cnt_hold_5", 32'(b0.toggle_cnt), 32'd5);

    // Reset with activity in the same cycle still clears
    rst   = 1'b1;
    b0.in = 1'b0;
    step();
    chk("cnt_rst_active", 32'(b0.toggle_cnt), 32'd0);
    rst = 1'b0;

    // 8-bit instance, mask 0F
    b1.in = 8'hA5;
    b1.bypass = 1'b0;
    settle();
    chk("w8_a5", 32'(b1.out), 32'hAA);
    b1.bypass = 1'b1;
    settle();
    chk("w8_a5_bypass", 32'(b1.out), 32'hA5);
    b1.bypass = 1'b0;
    b1.in = 8'h00;
    settle();
    chk("w8_00", 32'(b1.out), 32'h0F);
    b1.in = 8'hFF;
    settle();
    chk("w8_ff", 32'(b1.out), 32'hF0);
    v = 8'h3C;
    b1.in = v;
    settle();
    chk("w8_3c", 32'(b1.out), 32'h33);

    // 3-bit counter: six changes, pause, then more changes than it can hold
    rst   = 1'b1;
    b2.in = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b2.in = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    step();
    chk("cnt3_six", 32'(b2.toggle_cnt), 32'd6);
    for (int i = 0; i < 4; i++) begin
      b2.in = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    step();
    chk("cnt3_sat", 32'(b2.toggle_cnt), 32'd7);
    for (int i = 0; i < 3; i++) begin
      b2.in = ~b2.in;
      step();
    end
    chk("cnt3_sat_hold", 32'(b2.toggle_cnt), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/black_box_inverter.md
Name: black_box_inverter

Overview:
- Parameterizable bitwise inverter, used as an external leaf primitive.
- Output is the bitwise inverse of the input on masked bits; by default every bit is inverted.
- Combinational data path by default, zero latency.
- A small clocked side block counts output changes for observability. This block is the only consumer of clock and reset unless the optional output register is compiled in.

Parameters:
- WIDTH, 1, data width in bits.
- INV_MASK, {WIDTH{1'b1}}, per-bit invert select: 1 = invert, 0 = pass through.
- CNT_W, 16, width of the output-change counter.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  data input.
- bypass  input  1  when 1, out = in (no inversion on any bit).
- out  output  WIDTH  data output.
- toggle_cnt  output  CNT_W  saturating count of cycles in which out differed from its previous-cycle value.

Behaviour:
- Data path (macro absent): out = bypass ? in : (in ^ INV_MASK). Purely combinational, zero latency. No dependency on clock or reset.
- Default configuration (WIDTH=1, INV_MASK=1, bypass=0):
  - in=1 gives out=0.
  - in=0 gives out=1.
  - Both hold in every cycle, including during reset.
- X/Z on in propagates bitwise; no masking of unknowns.
- Change counter state:
  - out_q (WIDTH): registered copy of out.
  - toggle_cnt (CNT_W).
- On a rising edge with reset=1: out_q <= INV_MASK (the output value for in=0, bypass=0), and toggle_cnt <= 0.
- On a rising edge with reset=0:
  - out_q <= out.
  - If out != out_q and toggle_cnt != all-ones, toggle_cnt increments by 1.
  - At all-ones, toggle_cnt holds (saturates, no wrap).
- The cycle in which reset deasserts performs a normal compare against the reset value of out_q.
- Reset asserted mid-operation clears toggle_cnt on the next edge, regardless of activity in that cycle.
- Multiple bits changing in one cycle count as a single increment.
- Reset values of outputs:
  - toggle_cnt = 0.
  - out is combinational (follows in) unless the register feature is enabled.

Optional Feature:
- Macro: BLACK_BOX_INVERTER_REG_OUT_EN.
- Defined:
  - out is registered: out <= bypass ? in : (in ^ INV_MASK) on each rising edge. One-cycle latency.
  - Reset value of out is INV_MASK.
  - The change counter compares against the registered out.
- Undefined: out is the combinational zero-latency path described above.
- Port list is identical in both builds.

Decomposition:
- Package black_box_inverter_pkg holds:
  - the default WIDTH and CNT_W constants;
  - a function computing the inverted value from (in, mask, bypass);
  - the reset-value helper.
- One natural sub-module: black_box_inverter_toggle_cnt. It holds the out_q register, the compare and the saturating counter, parameterized by WIDTH and CNT_W.

Test Plan:
- Default params, reset deasserted, in=1, bypass=0 → out=0 in the same cycle; check every cycle over 10 cycles.
- Default params, in=0 → out=1 every cycle. With reset held high, out still =1 (macro absent).
- WIDTH=8, INV_MASK=8'h0F, in=8'hA5 → out=8'hAA. Set bypass=1 → out=8'hA5 in the same cycle.
- Toggle in each cycle for 5 cycles after reset, starting from in=1 → toggle_cnt=5. Hold in constant → toggle_cnt stays 5. Assert reset for one cycle → toggle_cnt=0.
- CNT_W=3, toggle in for 10 cycles → toggle_cnt saturates at 7 and stays there.
- With BLACK_BOX_INVERTER_REG_OUT_EN defined:
  - after reset, out=INV_MASK;
  - drive in=1 (default params) → out=0 one cycle later, not in the same cycle.
